stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of requester and stack data.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports Req0/Req1  input  1  request from requester 0/1, held until its Ack.
REQ-005 SHALL have ports Op0/Op1  input  1  operation: 1 = push, 0 = pop; stable while Req high.
REQ-006 SHALL have ports Din0/Din1  input  DATA_W  push data; stable while Req high.
REQ-007 SHALL have ports Ack0/Ack1  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports Dout0/Dout1  output  DATA_W  pop result; valid in the Ack cycle, held until next Ack to the same requester.
REQ-009 SHALL have ports Err0/Err1  output  1  valid with Ack; 1 = rejected (push on full, pop on empty).
REQ-010 SHALL have port S_Push  output  1  one-cycle push strobe to the stack.
REQ-011 SHALL have port S_Pop  output  1  one-cycle pop strobe to the stack.
REQ-012 SHALL have port S_Data_In  output  DATA_W  data to the stack, valid with S_Push.
REQ-013 SHALL have port S_Data_Out  input  DATA_W  stack read data, valid the cycle after S_Pop.
REQ-014 SHALL have port S_Full  input  1  1 = stack holds maximum entries.
REQ-015 SHALL have port S_Avail  input  1  1 = stack holds at least one entry.
REQ-016 SHALL have port Busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; transitions only on Clk.
REQ-018 IDLE: if any Req high, SHALL latch winner index, Op, Din and go to ISSUE; else stay.
REQ-019 Arbitration SHALL be round-robin: one requester -> it wins; both -> the one not last granted wins.
REQ-020 Last-granted pointer SHALL update only on leaving IDLE; reset value favours requester 0.
REQ-021 ISSUE: push with S_Full=0 -> S_Push=1, S_Data_In=latched Din; pop with S_Avail=0... corrected: pop with S_Avail=1 -> S_Pop=1; otherwise no strobe and an error flag is latched; -> WAIT.
REQ-022 S_Full/S_Avail SHALL be sampled only in ISSUE; strobes SHALL never assert outside ISSUE.
REQ-023 WAIT: for a successful pop, SHALL capture S_Data_Out into the winner's Dout; -> RESP.
REQ-024 RESP: SHALL pulse winner's Ack for exactly one cycle with Err = latched error flag; -> IDLE.
REQ-025 Latency SHALL be fixed: Req sampled in IDLE at cycle t -> strobe at t+1 -> Ack at t+3.
REQ-026 Rejected push/pop SHALL leave the winner's Dout unchanged and stack untouched.
REQ-027 Loser's Req SHALL be ignored while Busy and served in the next IDLE without loss.
REQ-028 Req still high in the IDLE cycle after its Ack SHALL be treated as a new request.
REQ-029 Ack0 and Ack1 SHALL never be high in the same cycle; S_Push and S_Pop likewise.
REQ-030 Changes to Op/Din after the IDLE sample SHALL not affect the in-flight operation.

Reset
REQ-031 Rst high at a rising edge SHALL force IDLE, pointer -> favour 0, error flag 0, from any state.
REQ-032 Reset values: Ack0/1=0, Err0/1=0, Dout0/1=0, S_Push=0, S_Pop=0, S_Data_In=0, Busy=0.
REQ-033 Reset mid-operation SHALL abort with no Ack; a strobe already issued is not retracted.

Verification
REQ-034 Req0=1,Op0=1,Din0=8'hA5, S_Full=0 -> S_Push=1 with S_Data_In=8'hA5 at t+1, Ack0=1, Err0=0 at t+3.
REQ-035 Req1=1,Op1=0, S_Avail=1, S_Data_Out=8'h3C at t+2 -> Ack1=1, Dout1=8'h3C, Err1=0 at t+3.
REQ-036 Req0 and Req1 both pushing continuously, S_Full=0 -> grants alternate 0,1,0,1; no Ack overlap.
REQ-037 Push with S_Full=1 -> no S_Push, Ack=1, Err=1; pop with S_Avail=0 -> no S_Pop, Ack=1, Err=1, Dout unchanged.
REQ-038 Rst asserted during WAIT -> next cycle Busy=0, no Ack; then Req1 alone -> served normally with t+3 latency.

Source files
------------

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port stack.
// Each granted operation takes a fixed four-state trip: IDLE -> ISSUE -> WAIT -> RESP.
module stack_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Op0,
  input  logic              Op1,
  input  logic [DATA_W-1:0] Din0,
  input  logic [DATA_W-1:0] Din1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Dout0,
  output logic [DATA_W-1:0] Dout1,
  output logic              Err0,
  output logic              Err1,
  output logic              S_Push,
  output logic              S_Pop,
  output logic [DATA_W-1:0] S_Data_In,
  input  logic [DATA_W-1:0] S_Data_Out,
  input  logic              S_Full,
  input  logic              S_Avail,
  output logic              Busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic              last;    // index of the requester granted most recently
  logic              win;     // index of the requester being served
  logic              op_q;    // 1 = push
  logic [DATA_W-1:0] din_q;
  logic              err_q;
  logic [DATA_W-1:0] dout0_q;
  logic [DATA_W-1:0] dout1_q;
  logic              grant1;

  // Round-robin pick: requester 1 wins when alone, or when both ask and 0 went last.
  always_comb begin
    grant1 = Req1 & (~Req0 | ~last);
  end

  // FSM, request latch, error flag and per-requester pop results.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      win     <= 1'b0;
      op_q    <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req0 | Req1) begin
            win   <= grant1;
            last  <= grant1;
            op_q  <= grant1 ? Op1 : Op0;
            din_q <= grant1 ? Din1 : Din0;
            err_q <= 1'b0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          err_q <= op_q ? S_Full : ~S_Avail;
          state <= WAIT;
        end
        WAIT: begin
          if (!op_q && !err_q) begin
            if (win) dout1_q <= S_Data_Out;
            else     dout0_q <= S_Data_Out;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes, acknowledges and status decoded from state.
  always_comb begin
    S_Push    = (state == ISSUE) &  op_q & ~S_Full;
    S_Pop     = (state == ISSUE) & ~op_q &  S_Avail;
    S_Data_In = din_q;
    Ack0      = (state == RESP) & ~win;
    Ack1      = (state == RESP) &  win;
    Err0      = (state == RESP) & ~win & err_q;
    Err1      = (state == RESP) &  win & err_q;
    Dout0     = dout0_q;
    Dout1     = dout1_q;
    Busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: directed scenarios queue expected strobes
// and acknowledges; a negedge monitor pops and compares as the DUT produces them.
module tb_stack_arbiter;
  localparam int DATA_W = 8;

  logic              Clk = 1'b0;
  logic              Rst, Req0, Req1, Op0, Op1;
  logic [DATA_W-1:0] Din0, Din1;
  logic              Ack0, Ack1, Err0, Err1;
  logic [DATA_W-1:0] Dout0, Dout1;
  logic              S_Push, S_Pop;
  logic [DATA_W-1:0] S_Data_In, S_Data_Out;
  logic              S_Full, S_Avail, Busy;

  stack_arbiter #(.DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .Din0(Din0), .Din1(Din1), .Ack0(Ack0), .Ack1(Ack1), .Dout0(Dout0),
    .Dout1(Dout1), .Err0(Err0), .Err1(Err1), .S_Push(S_Push), .S_Pop(S_Pop),
    .S_Data_In(S_Data_In), .S_Data_Out(S_Data_Out), .S_Full(S_Full),
    .S_Avail(S_Avail), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic idx; logic err; logic [DATA_W-1:0] dout; } ack_t;
  typedef struct { logic push; logic [DATA_W-1:0] data; } strb_t;

  ack_t  ack_q[$];
  strb_t strb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DATA_W-1:0] exp_d0 = '0;
  logic [DATA_W-1:0] exp_d1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_ack(input logic idx, input logic err);
    ack_t e;
    e.idx = idx;
    e.err = err;
    e.dout = idx ? exp_d1 : exp_d0;
    ack_q.push_back(e);
  endtask

  task automatic exp_strobe(input logic push, input logic [DATA_W-1:0] data);
    strb_t e;
    e.push = push;
    e.data = data;
    strb_q.push_back(e);
  endtask

  // Monitor: strobes must appear in the first busy cycle, Ack two cycles later.
  int   cyc = 0;
  int   issue_cyc = -100;
  logic busy_prev = 1'b0;
  ack_t  ea;
  strb_t es;
  always @(negedge Clk) begin
    cyc++;
    if (Busy && !busy_prev) issue_cyc = cyc;
    busy_prev = Busy;
    if (S_Push || S_Pop) begin
      check("strobe_overlap", {31'd0, S_Push & S_Pop}, 0);
      if (strb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        es = strb_q.pop_front();
        check("strobe_push", {31'd0, S_Push}, {31'd0, es.push});
        if (es.push) check("s_data_in", {24'd0, S_Data_In}, {24'd0, es.data});
        check("strobe_latency", cyc, issue_cyc);
      end
    end
    if (Ack0 || Ack1) begin
      check("ack_overlap", {31'd0, Ack0 & Ack1}, 0);
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        ea = ack_q.pop_front();
        check("ack_idx", {31'd0, Ack1}, {31'd0, ea.idx});
        check("ack_err", {31'd0, ea.idx ? Err1 : Err0}, {31'd0, ea.err});
        check("other_err", {31'd0, ea.idx ? Err0 : Err1}, 0);
        check("ack_dout", {24'd0, ea.idx ? Dout1 : Dout0}, {24'd0, ea.dout});
        check("ack_latency", cyc, issue_cyc + 2);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Waits (bounded) for n acknowledges, then drops both requests.
  task automatic wait_acks(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 200) begin
      @(negedge Clk);
      budget++;
      if (Ack0 || Ack1) seen++;
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    check("ack_count", seen, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, Busy}, 0);
    check({tag, "_acks"}, {30'd0, Ack1, Ack0}, 0);
    check({tag, "_errs"}, {30'd0, Err1, Err0}, 0);
    check({tag, "_strobes"}, {30'd0, S_Pop, S_Push}, 0);
    check({tag, "_douts"}, {16'd0, Dout1, Dout0}, 0);
    check({tag, "_sdin"}, {24'd0, S_Data_In}, 0);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    exp_d0 = '0;
    exp_d1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; Din0 = '0; Din1 = '0;
    S_Data_Out = '0; S_Full = 0; S_Avail = 0;
    tick(2);
    check_reset_outputs("reset");
    Rst = 1'b0;
    tick(2);

    // Push from requester 0.
    exp_strobe(1'b1, 8'hA5);
    exp_ack(1'b0, 1'b0);
    Op0 = 1; Din0 = 8'hA5; Req0 = 1;
    wait_acks(1);
    tick(2);

    // Pop from requester 1.
    S_Avail = 1; S_Data_Out = 8'h3C;
    exp_strobe(1'b0, 8'h00);
    exp_d1 = 8'h3C;
    exp_ack(1'b1, 1'b0);
    Op1 = 0; Req1 = 1;
    wait_acks(1);
    tick(2);

    // Both pushing continuously: last grant was 1, so 0,1,0,1.
    Op0 = 1; Din0 = 8'h11; Op1 = 1; Din1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_strobe(1'b1, (i % 2 == 0) ? 8'h11 : 8'h22);
      exp_ack((i % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
    end
    Req0 = 1; Req1 = 1;
    wait_acks(4);
    tick(2);

    // Push on full stack: rejected.
    S_Full = 1;
    exp_ack(1'b0, 1'b1);
    Op0 = 1; Din0 = 8'h5E; Req0 = 1;
    wait_acks(1);
    S_Full = 0;
    tick(2);

    // Pop on empty stack: rejected, Dout1 keeps 3C.
    S_Avail = 0; S_Data_Out = 8'h77;
    exp_ack(1'b1, 1'b1);
    Op1 = 0; Req1 = 1;
    wait_acks(1);
    tick(2);

    // Op/Din change after the IDLE sample must not affect the pop.
    S_Avail = 1; S_Data_Out = 8'h5A;
    exp_strobe(1'b0, 8'h00);
    exp_d0 = 8'h5A;
    exp_ack(1'b0, 1'b0);
    Op0 = 0; Din0 = 8'h99; Req0 = 1;
    tick(1);
    Op0 = 1; Din0 = 8'hEE;
    wait_acks(1);
    tick(2);

    // Reset during WAIT aborts without Ack; then requester 1 alone is served.
    exp_strobe(1'b1, 8'h44);
    Op0 = 1; Din0 = 8'h44; Req0 = 1;
    tick(2);
    Req0 = 0;
    pulse_reset();
    check_reset_outputs("abort");
    tick(3);
    S_Avail = 1; S_Data_Out = 8'hC3;
    exp_strobe(1'b0, 8'h00);
    exp_d1 = 8'hC3;
    exp_ack(1'b1, 1'b0);
    Op1 = 0; Req1 = 1;
    wait_acks(1);
    tick(2);

    // Pointer returns to favouring 0 after reset even when 0 went last.
    exp_strobe(1'b1, 8'h01);
    exp_ack(1'b0, 1'b0);
    Op0 = 1; Din0 = 8'h01; Req0 = 1;
    wait_acks(1);
    tick(1);
    pulse_reset();
    tick(1);
    Op0 = 1; Din0 = 8'h0A; Op1 = 1; Din1 = 8'h0B;
    exp_strobe(1'b1, 8'h0A);
    exp_ack(1'b0, 1'b0);
    exp_strobe(1'b1, 8'h0B);
    exp_ack(1'b1, 1'b0);
    Req0 = 1; Req1 = 1;
    wait_acks(2);
    tick(5);

    check("ack_queue_empty", ack_q.size(), 0);
    check("strobe_queue_empty", strb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
